// File: rtl/adc_pkg.sv
// Shared types for the TI-ADC frame packer.
package adc_pkg;

  localparam int ADC_WAYS = 8;
  localparam int ADC_BITS = 9;

  typedef struct packed {
    logic [ADC_WAYS*ADC_BITS-1:0] data;
    logic                         last;
  } frame_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_DRAIN
  } state_t;

endpackage

// File: rtl/adc_frame_fifo.sv
// Frame FIFO: power-of-two ring with separate occupancy count.
module adc_frame_fifo #(
  parameter int W     = 73,
  parameter int DEPTH = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         i_push,
  input  logic [W-1:0] i_din,
  input  logic         i_pop,
  output logic [W-1:0] o_dout,
  output logic         o_empty,
  output logic         o_full
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_count;

  logic w_pop;
  logic w_push;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);

  // Head reads as zero when empty so reset leaves a clean bus.
  assign o_dout = o_empty ? '0 : r_mem[r_rd];

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr] <= i_din;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/adc_frame_packer.sv
// Packs eight offset-binary ADC lanes into two's-complement frames
// for a bounded capture, with drop accounting on FIFO overflow.
module adc_frame_packer
  import adc_pkg::*;
#(
  parameter int WAYS  = ADC_WAYS,
  parameter int BITS  = ADC_BITS,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [BITS-1:0]      adcout0,
  input  logic [BITS-1:0]      adcout1,
  input  logic [BITS-1:0]      adcout2,
  input  logic [BITS-1:0]      adcout3,
  input  logic [BITS-1:0]      adcout4,
  input  logic [BITS-1:0]      adcout5,
  input  logic [BITS-1:0]      adcout6,
  input  logic [BITS-1:0]      adcout7,
  input  logic                 in_valid,
  input  logic                 arm,
  input  logic [CNT_W-1:0]     frames,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WAYS*BITS-1:0] out_data,
  output logic                 out_last,
  output logic                 busy,
  output logic                 overflow,
  output logic [CNT_W-1:0]     drop_count
);

  state_t           r_state;
  logic [CNT_W-1:0] r_rem;
  logic             r_ovf;
  logic [CNT_W-1:0] r_drop;

  logic [BITS-1:0]      w_lane [8];
  logic [WAYS*BITS-1:0] w_data;
  logic                 w_empty;
  logic                 w_full;
  logic                 w_take;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_last;

  assign w_lane[0] = adcout0;
  assign w_lane[1] = adcout1;
  assign w_lane[2] = adcout2;
  assign w_lane[3] = adcout3;
  assign w_lane[4] = adcout4;
  assign w_lane[5] = adcout5;
  assign w_lane[6] = adcout6;
  assign w_lane[7] = adcout7;

  // Offset binary to two's complement: flip the MSB.
  for (genvar i = 0; i < WAYS; i++) begin : g_lane
    assign w_data[BITS*i +: BITS] =
      {~w_lane[i][BITS-1], w_lane[i][BITS-2:0]};
  end

  assign w_take = (r_state == S_CAPTURE) && in_valid;
  assign w_pop  = !w_empty && out_ready;
  assign w_push = w_take && (!w_full || w_pop);
  assign w_last = (r_rem == CNT_W'(1));

  adc_frame_fifo #(
    .W     (WAYS*BITS+1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (w_push),
    .i_din   ({w_last, w_data}),
    .i_pop   (w_pop),
    .o_dout  ({out_last, out_data}),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  assign out_valid  = !w_empty;
  assign busy       = (r_state != S_IDLE);
  assign overflow   = r_ovf;
  assign drop_count = r_drop;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_rem   <= '0;
      r_ovf   <= 1'b0;
      r_drop  <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (arm && frames != '0) begin
            r_state <= S_CAPTURE;
            r_rem   <= frames;
            r_ovf   <= 1'b0;
            r_drop  <= '0;
          end
        end
        S_CAPTURE: begin
          if (in_valid) begin
            r_rem <= r_rem - 1'b1;
            if (!w_push) begin
              r_ovf <= 1'b1;
              if (r_drop != '1) r_drop <= r_drop + 1'b1;
            end
            if (w_last) r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_empty) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_frame_packer.sv
// Directed bench for adc_frame_packer.
module tb_adc_frame_packer;

  logic        clock;
  logic        reset;
  logic [8:0]  lane [8];
  logic        in_valid;
  logic        arm;
  logic [15:0] frames;
  logic        out_valid;
  logic        out_ready;
  logic [71:0] out_data;
  logic        out_last;
  logic        busy;
  logic        overflow;
  logic [15:0] drop_count;

  int total = 0;
  int bad   = 0;

  adc_frame_packer dut (
    .clock      (clock),
    .reset      (reset),
    .adcout0    (lane[0]),
    .adcout1    (lane[1]),
    .adcout2    (lane[2]),
    .adcout3    (lane[3]),
    .adcout4    (lane[4]),
    .adcout5    (lane[5]),
    .adcout6    (lane[6]),
    .adcout7    (lane[7]),
    .in_valid   (in_valid),
    .arm        (arm),
    .frames     (frames),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [79:0] obs,
                     input logic [79:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // All lanes = 9'h100 + k, which converts to k in every lane.
  task automatic set_all(input int k);
    for (int i = 0; i < 8; i++) lane[i] = 9'(9'h100 + k);
  endtask

  function automatic logic [71:0] pat(input int k);
    logic [71:0] p;
    for (int i = 0; i < 8; i++) p[9*i +: 9] = 9'(k);
    return p;
  endfunction

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk(tag, busy, 0);
  endtask

  logic [71:0] e2;

  initial begin
    reset = 1'b1;
    arm = 1'b0;
    frames = '0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    set_all(0);
    repeat (2) @(negedge clock);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_drop", drop_count, 0);
    chk("rst_data", out_data, 0);
    chk("rst_last", out_last, 0);
    reset = 1'b0;
    @(negedge clock);

    // Three frames of 9'h100 with a ready consumer
    arm = 1'b1;
    frames = 16'd3;
    out_ready = 1'b1;
    @(negedge clock);
    chk("t1_busy", busy, 1);
    arm = 1'b0;
    in_valid = 1'b1;
    @(negedge clock);
    chk("t1_v1", out_valid, 1);
    chk("t1_d1", out_data, 0);
    chk("t1_l1", out_last, 0);
    @(negedge clock);
    chk("t1_d2", out_data, 0);
    chk("t1_l2", out_last, 0);
    @(negedge clock);
    chk("t1_v3", out_valid, 1);
    chk("t1_l3", out_last, 1);
    in_valid = 1'b0;
    @(negedge clock);
    chk("t1_empty", out_valid, 0);
    wait_idle("t1_idle");

    // Ramp across lanes, single frame
    for (int i = 0; i < 8; i++) lane[i] = 9'(9'h0FF + i);
    e2 = {9'h006, 9'h005, 9'h004, 9'h003,
          9'h002, 9'h001, 9'h000, 9'h1FF};
    arm = 1'b1;
    frames = 16'd1;
    @(negedge clock);
    arm = 1'b0;
    in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    chk("t2_data", out_data, e2);
    chk("t2_last", out_last, 1);
    wait_idle("t2_idle");

    // Stalled consumer: 6 slots into a 4-deep FIFO
    out_ready = 1'b0;
    arm = 1'b1;
    frames = 16'd6;
    @(negedge clock);
    arm = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      set_all(k);
      in_valid = 1'b1;
      @(negedge clock);
      if (k == 4) begin
        chk("t3_ovf4", overflow, 0);
        chk("t3_drop4", drop_count, 0);
      end
      if (k == 5) begin
        chk("t3_ovf5", overflow, 1);
        chk("t3_drop5", drop_count, 1);
      end
    end
    in_valid = 1'b0;
    chk("t3_ovf", overflow, 1);
    chk("t3_drop", drop_count, 2);
    chk("t3_valid", out_valid, 1);
    chk("t3_head", out_data, pat(1));
    repeat (3) @(negedge clock);
    chk("t3_drain_busy", busy, 1);
    chk("t3_hold", out_data, pat(1));
    chk("t3_hold_last", out_last, 0);
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("t3_d%0d", k), out_data, pat(k));
      chk($sformatf("t3_l%0d", k), out_last, 0);
      @(negedge clock);
    end
    chk("t3_empty", out_valid, 0);
    wait_idle("t3_idle");

    // Full FIFO with simultaneous push and pop
    out_ready = 1'b0;
    arm = 1'b1;
    frames = 16'd5;
    @(negedge clock);
    arm = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      set_all(k);
      in_valid = 1'b1;
      @(negedge clock);
    end
    chk("t4_full_drop", drop_count, 0);
    set_all(5);
    out_ready = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    chk("t4_drop", drop_count, 0);
    chk("t4_ovf", overflow, 0);
    for (int k = 2; k <= 5; k++) begin
      chk($sformatf("t4_d%0d", k), out_data, pat(k));
      chk($sformatf("t4_l%0d", k), out_last, (k == 5));
      @(negedge clock);
    end
    chk("t4_empty", out_valid, 0);
    wait_idle("t4_idle");

    // Ignored arms
    arm = 1'b1;
    frames = 16'd0;
    @(negedge clock);
    chk("t5_zero_arm", busy, 0);
    frames = 16'd2;
    @(negedge clock);
    chk("t5_armed", busy, 1);
    frames = 16'd7;
    set_all(1);
    in_valid = 1'b1;
    @(negedge clock);
    set_all(2);
    @(negedge clock);
    in_valid = 1'b0;
    arm = 1'b0;
    chk("t5_data", out_data, pat(2));
    chk("t5_last", out_last, 1);
    wait_idle("t5_idle");

    // Asynchronous reset mid-capture
    out_ready = 1'b0;
    arm = 1'b1;
    frames = 16'd4;
    @(negedge clock);
    arm = 1'b0;
    set_all(3);
    in_valid = 1'b1;
    repeat (2) @(negedge clock);
    chk("t6_pre_valid", out_valid, 1);
    chk("t6_pre_busy", busy, 1);
    #2 reset = 1'b1;
    #1;
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_data", out_data, 0);
    in_valid = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    chk("t6_post_valid", out_valid, 0);
    chk("t6_post_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
